// File: rtl/xor_stream_cipher_if.sv
// Valid/ready stream bundle for xor_stream_cipher.
// master drives plaintext, rekey, out_ready; slave drives ciphertext.
interface xor_stream_cipher_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             rekey;
  logic [WIDTH-1:0] seed_in;
  logic [CNT_W-1:0] beat_count;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    output rekey,
    output seed_in,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  beat_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    input  rekey,
    input  seed_in,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output beat_count
  );
endinterface

// File: rtl/xor_stream_cipher.sv
// One-stage XOR stream cipher: static, combined or LFSR keystream.
// Ports: clk, rst (sync, high), bus (slave: in/out stream, rekey, count).
module xor_stream_cipher #(
  parameter int               WIDTH = 8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] KEY1  = WIDTH'(8'hAA),
  parameter logic [WIDTH-1:0] KEY2  = WIDTH'(8'hA8),
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
  parameter int               CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  xor_stream_cipher_if.slave bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] ks_q;

  logic             ready;
  logic             accept;
  logic             fire;
  logic [WIDTH-1:0] key;
  logic [WIDTH-1:0] ks_next;
  logic [WIDTH-1:0] seed_fix;

  assign ready  = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && ready;
  assign fire   = out_valid_q && bus.out_ready;

  // Galois step, right-shift form.
  assign ks_next = {1'b0, ks_q[WIDTH-1:1]}
                 ^ (ks_q[0] ? POLY : '0);

  // A zero seed would lock the LFSR.
  assign seed_fix = (bus.seed_in == '0)
                  ? WIDTH'(1)
                  : bus.seed_in;

  always_comb begin
    key = KEY1;
    case (MODE)
      0:       key = KEY2;
      1:       key = KEY1 ^ KEY2;
      2:       key = ks_q;
      default: key = KEY1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data ^ key;
      out_last_q  <= bus.in_last;
    end else if (fire) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Rekey beats a same-cycle accept; that beat
  // already used the old ks above.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q <= SEED;
      ks_q   <= SEED;
    end else if (MODE == 2) begin
      if (bus.rekey) begin
        seed_q <= seed_fix;
        ks_q   <= seed_fix;
      end else if (accept) begin
        ks_q <= bus.in_last ? seed_q : ks_next;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.beat_count = count_q;

endmodule
